conv2_outread: RTL and testbench

//  Reader for the conv2 result BRAM. On start, reads words 0..DEPTH-1 in order through BRAM port B.

---
 rtl/conv2_outread_if.sv | 26 ++
 rtl/conv2_outread.sv | 180 ++++++++++++++++++
 tb/tb_conv2_outread.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv2_outread_if.sv
// rtl/conv2_outread_if.sv - conv2 result reader control, BRAM port-B and output stream bundle
interface conv2_outread_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 128
);
  logic              start;
  logic              busy;
  logic              done;
  logic              enb2;
  logic [ADDR_W-1:0] addrb2;
  logic [DATA_W-1:0] doutb2;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    input  start, doutb2, out_ready,
    output busy, done, enb2, addrb2, out_valid, out_data, out_last
  );

  modport slave (
    output start, doutb2, out_ready,
    input  busy, done, enb2, addrb2, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv2_outread.sv
// rtl/conv2_outread.sv - streams conv2 result BRAM words 0..DEPTH-1 downstream
// Reads are credit-limited so every in-flight BRAM word always has a FIFO slot.
module conv2_outread #(
  parameter int DEPTH  = 1260,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 128,
  parameter int RD_LAT = 2,
  parameter int FIFO_D = 4
) (
  input  logic             clk,
  input  logic             rst,
  conv2_outread_if.master  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // The output register is the FIFO head slot; the ring buffer holds the rest.
  localparam int BUF_D = FIFO_D - 1;
  localparam int PTR_W = (BUF_D > 1) ? $clog2(BUF_D) : 1;
  localparam int CNT_W = $clog2(FIFO_D + RD_LAT + 1) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] rd_addr;
  logic [RD_LAT-1:0] sr_v;
  logic [RD_LAT-1:0] sr_l;

  logic [DATA_W-1:0] buf_data [BUF_D];
  logic [BUF_D-1:0]  buf_last;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  buf_cnt;

  logic              out_valid_q;
  logic              out_last_q;
  logic [DATA_W-1:0] out_data_q;

  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  used;
  logic              issue;
  logic              push;
  logic              push_last;
  logic              pop;
  logic              out_free;
  logic              buf_rd;
  logic              buf_wr;
  logic              last_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_D - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CNT_W'(sr_v[i]);
    end
  end

  assign used      = buf_cnt + CNT_W'(out_valid_q) + inflight;
  assign issue     = (state == S_READ) && (used < CNT_W'(FIFO_D));
  assign push      = sr_v[RD_LAT-1];
  assign push_last = sr_l[RD_LAT-1];
  assign pop       = out_valid_q && bus.out_ready;
  assign out_free  = !out_valid_q || pop;
  assign buf_rd    = out_free && (buf_cnt != '0);
  // A push bypasses the ring only when the head slot frees up and nothing is queued ahead.
  assign buf_wr    = push && !(out_free && (buf_cnt == '0));
  assign last_pop  = pop && out_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      rd_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state   <= S_READ;
            rd_addr <= '0;
          end
        end
        S_READ: begin
          if (issue) begin
            if (rd_addr == LAST_ADDR) begin
              state <= S_DRAIN;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (last_pop && (inflight == '0) && (buf_cnt == '0)) begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_v <= '0;
      sr_l <= '0;
    end else begin
      sr_v[0] <= issue;
      sr_l[0] <= issue && (rd_addr == LAST_ADDR);
      for (int i = 1; i < RD_LAT; i++) begin
        sr_v[i] <= sr_v[i-1];
        sr_l[i] <= sr_l[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (buf_wr) begin
      buf_data[wr_ptr] <= bus.doutb2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_last <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      buf_cnt  <= '0;
    end else begin
      if (buf_wr) begin
        buf_last[wr_ptr] <= push_last;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (buf_rd) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({buf_wr, buf_rd})
        2'b10:   buf_cnt <= buf_cnt + 1'b1;
        2'b01:   buf_cnt <= buf_cnt - 1'b1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  // Head slot only reloads when empty or being popped, so data holds under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (out_free) begin
      if (buf_rd) begin
        out_valid_q <= 1'b1;
        out_data_q  <= buf_data[rd_ptr];
        out_last_q  <= buf_last[rd_ptr];
      end else if (push) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.doutb2;
        out_last_q  <= push_last;
      end else begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    !(buf_wr && !buf_rd && (buf_cnt == CNT_W'(BUF_D))));

  assign bus.enb2      = issue;
  assign bus.addrb2    = rd_addr;
  assign bus.busy      = (state == S_READ) || (state == S_DRAIN);
  assign bus.done      = (state == S_DONE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_conv2_outread.sv
// tb/tb_conv2_outread.sv - randomized self-checking bench for conv2_outread against a word-order model
module tb_conv2_outread;
  localparam int DEPTH  = 1260;
  localparam int FIFO_D = 4;
  localparam int D6     = 3;

  logic clk = 1'b0;
  logic rst;
  logic rst6;
  always #5 clk = ~clk;

  conv2_outread_if #(.ADDR_W(11), .DATA_W(128)) bus ();
  conv2_outread_if #(.ADDR_W(11), .DATA_W(128)) bus6 ();

  conv2_outread #(.DEPTH(DEPTH), .ADDR_W(11), .DATA_W(128), .RD_LAT(2), .FIFO_D(FIFO_D))
    dut (.clk(clk), .rst(rst), .bus(bus));
  conv2_outread #(.DEPTH(D6), .ADDR_W(11), .DATA_W(128), .RD_LAT(1), .FIFO_D(2))
    dut6 (.clk(clk), .rst(rst6), .bus(bus6));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Memory image: every channel byte of word a carries a[7:0], optionally scrambled by a pass key.
  function automatic logic [127:0] word(input logic [10:0] a, input logic [31:0] k);
    return {16{a[7:0]}} ^ {4{k}};
  endfunction

  logic [31:0] key = '0;
  logic [31:0] key6 = '0;
  logic [10:0] p1_a = '0, p2_a = '0, q1_a = '0;
  always @(posedge clk) begin
    if (bus.enb2) p1_a <= bus.addrb2;
    p2_a <= p1_a;
    if (bus6.enb2) q1_a <= bus6.addrb2;
  end
  assign bus.doutb2  = word(p2_a, key);
  assign bus6.doutb2 = word(q1_a, key6);

  // Model state for the main instance: words must leave strictly in address order.
  int issued, hs, n_done, n_last, s_cyc, first_rel, last_rel, done_rel;
  bit stalled;
  logic [127:0] hold_data, last_data;
  logic hold_last;

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
      chk("rst_done_low", bus.done, 1'b0);
    end else begin
      if (bus.enb2) begin
        chk("issue_addr", bus.addrb2, issued);
        chk("issue_in_range", issued < DEPTH, 1'b1);
        issued++;
      end
      chk("credit_limit", (issued - hs) <= FIFO_D, 1'b1);
      if (stalled) begin
        chk("hold_valid", bus.out_valid, 1'b1);
        chk("hold_data", bus.out_data, hold_data);
        chk("hold_last", bus.out_last, hold_last);
      end
      if (bus.out_valid) begin
        chk("out_data", bus.out_data, word(11'(hs), key));
        chk("out_last", bus.out_last, hs == DEPTH - 1);
        if (first_rel < 0) first_rel = cyc - s_cyc;
        if (bus.out_ready) begin
          hs++;
          last_rel  = cyc - s_cyc;
          last_data = bus.out_data;
          if (bus.out_last) n_last++;
        end
      end
      stalled   = bus.out_valid && !bus.out_ready;
      hold_data = bus.out_data;
      hold_last = bus.out_last;
      if (bus.done) begin
        n_done++;
        done_rel = cyc - s_cyc;
        chk("done_all_words", hs, DEPTH);
        chk("done_busy_low", bus.busy, 1'b0);
      end
    end
  end

  int hs6, n_done6, n_last6, issued6, last_hs6_cyc;
  logic [127:0] last_data6;
  always @(negedge clk) begin
    if (!rst6) begin
      if (bus6.enb2) begin
        chk("t6_issue_addr", bus6.addrb2, issued6);
        issued6++;
      end
      if (bus6.out_valid) begin
        chk("t6_out_data", bus6.out_data, word(11'(hs6), key6));
        chk("t6_out_last", bus6.out_last, hs6 == D6 - 1);
        if (bus6.out_ready) begin
          hs6++;
          last_hs6_cyc = cyc;
          last_data6   = bus6.out_data;
          if (bus6.out_last) n_last6++;
        end
      end
      if (bus6.done) begin
        n_done6++;
        chk("t6_done_after_last", cyc, last_hs6_cyc + 1);
        chk("t6_done_words", hs6, D6);
      end
    end
  end

  function automatic logic ready_for(input int mode, input int rel);
    case (mode)
      0:       return 1'b1;
      1:       return (rel % 4 == 0) || (rel % 4 == 3);
      2:       return rel >= 50;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // Entered and left at posedge+1, so back-to-back calls start in the cycle after done.
  task automatic run_pass(input int mode, input bit t4, input int abort_at, input logic [31:0] k);
    int rel;
    bit aborted;
    key = k;
    issued = 0; hs = 0; n_done = 0; n_last = 0; stalled = 1'b0;
    first_rel = -1; last_rel = -1; done_rel = -1;
    bus.start = 1'b1;
    s_cyc = cyc;
    bus.out_ready = ready_for(mode, 0);
    rel = 0;
    aborted = 1'b0;
    while (n_done == 0 && rel < 6000 && !aborted) begin
      @(posedge clk); #1;
      rel++;
      bus.start = t4 && (rel == 100);
      bus.out_ready = ready_for(mode, rel);
      if (rel == 1) chk("busy_after_start", bus.busy, 1'b1);
      if (t4 && rel == 101) chk("t4_busy_kept", bus.busy, 1'b1);
      if (mode == 2 && rel == 50) begin
        chk("t3_issued", issued, FIFO_D);
        chk("t3_enb2_low", bus.enb2, 1'b0);
        chk("t3_no_words", hs, 0);
      end
      if (abort_at > 0 && hs >= abort_at) begin
        #2 rst = 1'b1;
        #1;
        chk("t5_enb2", bus.enb2, 1'b0);
        chk("t5_addrb2", bus.addrb2, 0);
        chk("t5_busy", bus.busy, 1'b0);
        chk("t5_out_valid", bus.out_valid, 1'b0);
        chk("t5_out_last", bus.out_last, 1'b0);
        chk("t5_out_data", bus.out_data, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        aborted = 1'b1;
      end
    end
    if (aborted) begin
      repeat (5) begin @(posedge clk); #1; end
      chk("t5_no_done", n_done, 0);
    end else begin
      chk("pass_done_once", n_done, 1);
      chk("pass_words", hs, DEPTH);
      chk("pass_one_last", n_last, 1);
      if (mode == 0) begin
        chk("first_valid_rel", first_rel, 4);
        chk("last_word_rel", last_rel, 1263);
        chk("done_rel", done_rel, 1264);
      end
    end
  endtask

  task automatic run6(input logic [31:0] k);
    int rel;
    key6 = k;
    hs6 = 0; n_done6 = 0; n_last6 = 0; issued6 = 0; last_hs6_cyc = -100;
    bus6.start = 1'b1;
    rel = 0;
    while (n_done6 == 0 && rel < 100) begin
      @(posedge clk); #1;
      rel++;
      bus6.start = 1'b0;
    end
    chk("t6_done_once", n_done6, 1);
    chk("t6_words", hs6, D6);
    chk("t6_one_last", n_last6, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rst6 = 1'b1;
    bus.start = 1'b0; bus.out_ready = 1'b0;
    bus6.start = 1'b0; bus6.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_enb2", bus.enb2, 1'b0);
    chk("reset_addrb2", bus.addrb2, 0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_out_last", bus.out_last, 1'b0);
    chk("reset_out_data", bus.out_data, 0);
    rst = 1'b0; rst6 = 1'b0;
    @(posedge clk); #1;

    run_pass(0, 1'b0, 0, 32'h0);
    chk("t1_last_word", last_data, {16{8'heb}});
    run_pass(1, 1'b0, 0, $urandom);
    run_pass(2, 1'b0, 0, $urandom);
    run_pass(0, 1'b1, 0, $urandom);
    run_pass(3, 1'b0, 600, $urandom);
    run_pass(3, 1'b0, 0, $urandom);

    run6(32'h0);
    chk("t6_last_word", last_data6, {16{8'h02}});
    run6($urandom);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
